mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the combinational single-cycle ALU. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over multiple clock cycles. The core stalls the PC while busy_o is high. Operands enter with a start/ready handshake; the result returns with a one-cycle done_o pulse and a held result register.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_abs.sv | 12 +
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement: passes val_i through, or negates it when neg_i is set.
module mdu_abs #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction applied on the final iteration.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       MD_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             start_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] MD_Result_o,
    output logic             Zero_o
);

    localparam int unsigned W2 = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_signed_c, b_signed_c, a_neg_c, b_neg_c, neg_c;
    logic             div_zero_c, ovf_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;

    // Operand signedness and RISC-V special cases, decoded from the live request.
    always_comb begin
        a_signed_c = (MD_Operation_i != MD_MULHU) && (MD_Operation_i != MD_DIVU)
                     && (MD_Operation_i != MD_REMU);
        b_signed_c = (MD_Operation_i == MD_MUL) || (MD_Operation_i == MD_MULH)
                     || (MD_Operation_i == MD_DIV) || (MD_Operation_i == MD_REM);
        a_neg_c    = a_signed_c && A_i[WIDTH-1];
        b_neg_c    = b_signed_c && B_i[WIDTH-1];
        neg_c      = (MD_Operation_i == MD_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
        div_zero_c = MD_Operation_i[2] && (B_i == '0);
        ovf_c      = ((MD_Operation_i == MD_DIV) || (MD_Operation_i == MD_REM))
                     && (A_i == WIDTH'(INT_MIN)) && (&B_i);
    end

    mdu_abs #(.W(WIDTH)) u_abs_a (.val_i(A_i), .neg_i(a_neg_c), .res_o(a_mag_c));
    mdu_abs #(.W(WIDTH)) u_abs_b (.val_i(B_i), .neg_i(b_neg_c), .res_o(b_mag_c));

    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH+1:0] diff_c;
    logic             qbit_c;
    logic [W2-1:0]    step_c;
    logic [W2-1:0]    raw_c, fin_c;
    logic [WIDTH-1:0] final_c;

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_c = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh_c  = acc_q[W2-1:WIDTH-1];
        diff_c    = {1'b0, rem_sh_c} - {2'b00, opb_q};
        qbit_c    = ~diff_c[WIDTH+1];
        if (op_q[2]) begin
            step_c = {(qbit_c ? diff_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], qbit_c};
        end else begin
            step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
        end
        if (!op_q[2]) begin
            raw_c = step_c;
        end else if (op_q[1]) begin
            raw_c = {WIDTH'(0), step_c[W2-1:WIDTH]};
        end else begin
            raw_c = {WIDTH'(0), step_c[WIDTH-1:0]};
        end
    end

    mdu_abs #(.W(W2)) u_abs_res (.val_i(raw_c), .neg_i(neg_q), .res_o(fin_c));

    assign final_c = (op_q[2] || (op_q == MD_MUL)) ? fin_c[WIDTH-1:0] : fin_c[W2-1:WIDTH];

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d    = MD_Operation_i;
                    neg_d   = neg_c;
                    opb_d   = b_mag_c;
                    acc_d   = {WIDTH'(0), a_mag_c};
                    count_d = '0;
                    if (div_zero_c) begin
                        result_d = MD_Operation_i[1] ? A_i : '1;
                        state_d  = ST_DONE;
                    end else if (ovf_c) begin
                        result_d = MD_Operation_i[1] ? '0 : WIDTH'(INT_MIN);
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d   = step_c;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    result_d = final_c;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        zero_d  = (result_d == '0);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_CALC);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign MD_Result_o = result_q;
    assign Zero_o      = zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected result and latency queued at issue, checked at done_o.
module tb_mul_div_unit;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MD_Operation_i;
    logic [31:0] A_i, B_i;
    logic        start_i;
    logic        ready_o, busy_o, done_o, Zero_o;
    logic [31:0] MD_Result_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .MD_Operation_i(MD_Operation_i), .A_i(A_i), .B_i(B_i),
        .start_i(start_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .MD_Result_o(MD_Result_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    // Reference model built on native wide arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, sp;
        logic [63:0]        up;
        logic               ovf;
        sa  = $signed({{32{a[31]}}, a});
        sb  = $signed({{32{b[31]}}, b});
        ub  = $signed({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
            OP_MULHSU: begin sp = sa * ub; return sp[63:32]; end
            OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drives a request and returns #1 after its accept edge with start_i still high.
    task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input bit push);
        exp_t e;
        @(negedge clk);
        MD_Operation_i = op;
        A_i = a;
        B_i = b;
        start_i = 1'b1;
        e.res = exp_res;
        e.lat = is_special(op, a, b) ? 32'd1 : 32'd33;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done_o, optionally pokes a foreign start mid-run, then scores.
    task automatic wait_done(input int poke);
        int   cyc;
        bit   rdy_bad;
        exp_t e;
        cyc = 1;
        rdy_bad = 0;
        while (!done_o && cyc < 100) begin
            if (ready_o) rdy_bad = 1;
            if (poke != 0 && cyc == poke) begin
                MD_Operation_i = OP_DIVU;
                A_i = 32'h0000_1234;
                B_i = 32'h0000_0005;
                start_i = 1'b1;
            end else if (poke != 0 && cyc == poke + 1) begin
                start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 64'd1, 64'd0);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        check_val("done_seen", 64'(done_o), 64'd1);
        check_val("latency", 64'(cyc), 64'(e.lat));
        check_val("result", 64'(MD_Result_o), 64'(e.res));
        check_val("zero", 64'(Zero_o), 64'(e.res == 32'd0));
        check_val("ready_low", 64'(ready_o | rdy_bad), 64'd0);
        @(posedge clk);
        #1;
        check_val("done_pulse", 64'(done_o), 64'd0);
        check_val("ready_back", 64'(ready_o), 64'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res);
        accept_op(op, a, b, exp_res, 1'b1);
        start_i = 1'b0;
        wait_done(0);
    endtask

    initial begin
        bit          saw_done;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start_i = 1'b0;
        MD_Operation_i = '0;
        A_i = '0;
        B_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 64'(ready_o), 64'd1);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_done", 64'(done_o), 64'd0);
        check_val("rst_result", 64'(MD_Result_o), 64'd0);
        check_val("rst_zero", 64'(Zero_o), 64'd1);
        reset = 1'b0;

        run(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run(OP_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        run(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run(OP_DIVU,   32'd100,        32'd7,         32'd14);
        run(OP_REMU,   32'd100,        32'd7,         32'd2);
        run(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
        run(OP_REMU,   32'd5,          32'd0,         32'd5);
        run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Foreign start mid-CALC must be ignored.
        accept_op(OP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b1);
        start_i = 1'b0;
        check_val("calc_busy", 64'(busy_o), 64'd1);
        wait_done(5);

        // start_i held through DONE: second request accepted on the first IDLE cycle.
        accept_op(OP_MUL, 32'd12, 32'd11, 32'd132, 1'b1);
        MD_Operation_i = OP_REMU;
        A_i = 32'd100;
        B_i = 32'd7;
        sb_q.push_back('{res: 32'd2, lat: 32'd33});
        wait_done(0);
        @(posedge clk);
        #1;
        check_val("b2b_accept", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        wait_done(0);

        // Reset mid-CALC aborts without a done pulse.
        accept_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_ready", 64'(ready_o), 64'd1);
        check_val("abort_busy", 64'(busy_o), 64'd0);
        check_val("abort_done", 64'(done_o), 64'd0);
        check_val("abort_result", 64'(MD_Result_o), 64'd0);
        check_val("abort_zero", 64'(Zero_o), 64'd1);
        reset = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) saw_done = 1;
        end
        check_val("abort_no_done", 64'(saw_done), 64'd0);
        run(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = (i % 4 == 1) ? 32'($urandom_range(0, 300)) : $urandom;
            rb  = (i % 5 == 0) ? 32'd0 : (i % 4 == 2) ? 32'($urandom_range(1, 20)) : $urandom;
            run(rop, ra, rb, ref_md(rop, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
